// File: rtl/inst_queue_pkg.sv
// Shared constants and helpers for the dual-issue instruction queue.
//  D_WIDTH   instruction / PC width
//  IQ_DEPTH  default queue depth
//  CNT_*     push/pop count encodings
//  legal_cnt folds the unused encoding 3 onto "none"
package inst_queue_pkg;

   localparam int D_WIDTH  = 32;
   localparam int IQ_DEPTH = 8;

   localparam logic [1:0] CNT_NONE = 2'd0;
   localparam logic [1:0] CNT_ONE  = 2'd1;
   localparam logic [1:0] CNT_TWO  = 2'd2;

   function automatic logic [1:0] legal_cnt(input logic [1:0] cnt);
      return (cnt == 2'd3) ? CNT_NONE : cnt;
   endfunction

endpackage

// File: rtl/iq_ram.sv
// Storage array for the instruction queue.
//  clk                      clock
//  wr_en_a/addr_a/data_a    write port A (older pushed instruction)
//  wr_en_b/addr_b/data_b    write port B (younger pushed instruction)
//  rd_addr_a/rd_data_a      asynchronous read port A
//  rd_addr_b/rd_data_b      asynchronous read port B
// Contents are never reset; the queue masks stale entries with its valid flags.
module iq_ram
   import inst_queue_pkg::*;
#(
   parameter  int DEPTH = IQ_DEPTH,
   parameter  int DW    = 2 * D_WIDTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en_a,
   input  logic [AW-1:0] wr_addr_a,
   input  logic [DW-1:0] wr_data_a,
   input  logic          wr_en_b,
   input  logic [AW-1:0] wr_addr_b,
   input  logic [DW-1:0] wr_data_b,
   input  logic [AW-1:0] rd_addr_a,
   output logic [DW-1:0] rd_data_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic [DW-1:0] rd_data_b
);

   logic [DW-1:0] mem [DEPTH];

   // The two write addresses are always tail and tail+1, so they never collide.
   always_ff @(posedge clk) begin
      if (wr_en_a) mem[wr_addr_a] <= wr_data_a;
      if (wr_en_b) mem[wr_addr_b] <= wr_data_b;
   end

   assign rd_data_a = mem[rd_addr_a];
   assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/inst_queue.sv
// Dual-issue instruction queue between fetch and decode.
//  i_CLK, i_RST           clock, synchronous active-high reset
//  i_Flush                branch redirect: empties the queue next cycle
//  i_PushCntF             0/1/2 instructions pushed (3 = none)
//  i_Inst1F/i_PC1F        older fetched instruction and PC
//  i_Inst2F/i_PC2F        younger fetched instruction and PC
//  o_ReadyF               at least two free entries
//  i_PopCntD              0/1/2 instructions retired by decode (3 = none)
//  o_Inst1D/o_PC1D        oldest entry (0 when o_Valid1D=0)
//  o_Inst2D/o_PC2D        second-oldest entry (0 when o_Valid2D=0)
//  o_Valid1D/o_Valid2D    occupancy >= 1 / >= 2
//  o_Count                occupancy
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH   = IQ_DEPTH,
   parameter int I_WIDTH = D_WIDTH
) (
   input  logic                   i_CLK,
   input  logic                   i_RST,
   input  logic                   i_Flush,
   input  logic [1:0]             i_PushCntF,
   input  logic [I_WIDTH-1:0]     i_Inst1F,
   input  logic [I_WIDTH-1:0]     i_Inst2F,
   input  logic [I_WIDTH-1:0]     i_PC1F,
   input  logic [I_WIDTH-1:0]     i_PC2F,
   output logic                   o_ReadyF,
   input  logic [1:0]             i_PopCntD,
   output logic [I_WIDTH-1:0]     o_Inst1D,
   output logic [I_WIDTH-1:0]     o_Inst2D,
   output logic [I_WIDTH-1:0]     o_PC1D,
   output logic [I_WIDTH-1:0]     o_PC2D,
   output logic                   o_Valid1D,
   output logic                   o_Valid2D,
   output logic [$clog2(DEPTH):0] o_Count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * I_WIDTH;

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;

   logic [1:0]    push_req;
   logic [1:0]    pop_req;
   logic [1:0]    push_eff;
   logic [1:0]    pop_eff;
   logic          ready;
   logic          clear;

   logic          wr_en_a;
   logic          wr_en_b;
   logic [EW-1:0] rd_data_a;
   logic [EW-1:0] rd_data_b;

   assign clear = i_RST | i_Flush;

   always_comb begin
      push_req = legal_cnt(i_PushCntF);
      pop_req  = legal_cnt(i_PopCntD);
      // Ready comes only from the registered count, so a push can never
      // land on an entry being popped in the same cycle.
      ready    = (CW'(DEPTH) - count) >= CW'(2);
      push_eff = ready ? push_req : CNT_NONE;
      // Clamp to occupancy; when the request exceeds count, count is 0 or 1.
      pop_eff  = (CW'(pop_req) > count) ? count[1:0] : pop_req;
   end

   assign wr_en_a = !clear && (push_eff != CNT_NONE);
   assign wr_en_b = !clear && (push_eff == CNT_TWO);

   iq_ram #(
      .DEPTH (DEPTH),
      .DW    (EW)
   ) u_ram (
      .clk       (i_CLK),
      .wr_en_a   (wr_en_a),
      .wr_addr_a (tail),
      .wr_data_a ({i_Inst1F, i_PC1F}),
      .wr_en_b   (wr_en_b),
      .wr_addr_b (tail + AW'(1)),
      .wr_data_b ({i_Inst2F, i_PC2F}),
      .rd_addr_a (head),
      .rd_data_a (rd_data_a),
      .rd_addr_b (head + AW'(1)),
      .rd_data_b (rd_data_b)
   );

   always_ff @(posedge i_CLK) begin
      if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop_eff);
         tail  <= tail + AW'(push_eff);
         count <= count + CW'(push_eff) - CW'(pop_eff);
      end
   end

   assign o_ReadyF  = ready;
   assign o_Count   = count;
   assign o_Valid1D = (count != '0);
   assign o_Valid2D = (count >= CW'(2));

   assign o_Inst1D  = o_Valid1D ? rd_data_a[EW-1:I_WIDTH] : '0;
   assign o_PC1D    = o_Valid1D ? rd_data_a[I_WIDTH-1:0]  : '0;
   assign o_Inst2D  = o_Valid2D ? rd_data_b[EW-1:I_WIDTH] : '0;
   assign o_PC2D    = o_Valid2D ? rd_data_b[I_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

   localparam int DEPTH = 8;
   localparam int W     = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [1:0]    push_cnt;
   logic [W-1:0]  inst1, inst2, pc1, pc2;
   logic          ready;
   logic [1:0]    pop_cnt;
   logic [W-1:0]  inst1_d, inst2_d, pc1_d, pc2_d;
   logic          valid1, valid2;
   logic [3:0]    count;

   int checks   = 0;
   int failures = 0;

   logic [2*W-1:0] sb [$];
   int             seq_n = 0;

   inst_queue #(.DEPTH(DEPTH), .I_WIDTH(W)) dut (
      .i_CLK      (clk),
      .i_RST      (rst),
      .i_Flush    (flush),
      .i_PushCntF (push_cnt),
      .i_Inst1F   (inst1),
      .i_Inst2F   (inst2),
      .i_PC1F     (pc1),
      .i_PC2F     (pc2),
      .o_ReadyF   (ready),
      .i_PopCntD  (pop_cnt),
      .o_Inst1D   (inst1_d),
      .o_Inst2D   (inst2_d),
      .o_PC1D     (pc1_d),
      .o_PC2D     (pc2_d),
      .o_Valid1D  (valid1),
      .o_Valid2D  (valid2),
      .o_Count    (count)
   );

   always #5 clk = ~clk;

   // One clock of stimulus. Expected entries go into the scoreboard when
   // fetch pushes; entries leaving through decode are popped and compared.
   task automatic drive(input logic [1:0] pc, input logic [W-1:0] i1, input logic [W-1:0] p1,
                        input logic [W-1:0] i2, input logic [W-1:0] p2,
                        input logic [1:0] pop, input logic fl);
      int    pe;
      int    pu;
      logic  exp_ready;
      logic [2*W-1:0] e;
      push_cnt = pc; inst1 = i1; pc1 = p1; inst2 = i2; pc2 = p2;
      pop_cnt = pop; flush = fl;
      exp_ready = (DEPTH - sb.size()) >= 2;
      checks++;
      if (ready !== exp_ready) begin
         failures++;
         $display("FAIL ready_model: got %0b expected %0b (occ %0d)", ready, exp_ready, sb.size());
      end
      pu = (pc == 2'd3) ? 0 : int'(pc);
      pe = (pop == 2'd3) ? 0 : int'(pop);
      if (pe > sb.size()) pe = sb.size();
      if (!fl) begin
         for (int k = 0; k < pe; k++) begin
            e = sb.pop_front();
            checks++;
            if (k == 0 && {inst1_d, pc1_d} !== e) begin
               failures++;
               $display("FAIL sb_slot1: got %h/%h expected %h/%h", inst1_d, pc1_d, e[2*W-1:W], e[W-1:0]);
            end
            if (k == 1 && {inst2_d, pc2_d} !== e) begin
               failures++;
               $display("FAIL sb_slot2: got %h/%h expected %h/%h", inst2_d, pc2_d, e[2*W-1:W], e[W-1:0]);
            end
         end
         if (exp_ready) begin
            if (pu >= 1) sb.push_back({i1, p1});
            if (pu == 2) sb.push_back({i2, p2});
         end
      end else begin
         sb.delete();
      end
      @(posedge clk); #1;
      push_cnt = 2'd0; pop_cnt = 2'd0; flush = 1'b0;
      checks++;
      if (int'(count) !== sb.size()) begin
         failures++;
         $display("FAIL count_model: got %0d expected %0d", count, sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; push_cnt = 2'd2; pop_cnt = 2'd0;
      inst1 = 32'hDEAD0001; pc1 = 32'h100; inst2 = 32'hDEAD0002; pc2 = 32'h104;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; push_cnt = 2'd0;
      sb.delete();
      checks++;
      if (count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++;
      if (valid1 !== 1'b0 || valid2 !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %0b%0b expected 00", valid1, valid2);
      end
      checks++;
      if (inst1_d !== 32'h0) begin failures++; $display("FAIL reset_inst1: got %h expected 0", inst1_d); end
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b expected 1", ready); end
   endtask

   task automatic test_push_pair();
      drive(2'd2, 32'hE3A01001, 32'h0, 32'hE2811001, 32'h4, 2'd0, 1'b0);
      checks++;
      if (valid1 !== 1'b1 || valid2 !== 1'b1) begin
         failures++; $display("FAIL pair_valid: got %0b%0b expected 11", valid1, valid2);
      end
      checks++;
      if (inst1_d !== 32'hE3A01001) begin
         failures++; $display("FAIL pair_inst1: got %h expected E3A01001", inst1_d);
      end
      checks++;
      if (pc2_d !== 32'h4) begin failures++; $display("FAIL pair_pc2: got %h expected 4", pc2_d); end
      checks++;
      if (count !== 4'd2) begin failures++; $display("FAIL pair_count: got %0d expected 2", count); end
      drive(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(2'd2, 32'hA000_0000 + 2*i, 32'h1000 + 8*i, 32'hA000_0001 + 2*i, 32'h1004 + 8*i, 2'd0, 1'b0);
         if (i == 2) begin
            checks++;
            if (count !== 4'd6 || ready !== 1'b1) begin
               failures++; $display("FAIL fill_6: got count %0d ready %0b expected 6/1", count, ready);
            end
         end
      end
      checks++;
      if (count !== 4'd8 || ready !== 1'b0) begin
         failures++; $display("FAIL fill_8: got count %0d ready %0b expected 8/0", count, ready);
      end
      drive(2'd0, 0, 0, 0, 0, 2'd1, 1'b0);
      drive(2'd1, 32'hBAD0BAD0, 32'hFFC, 0, 0, 2'd0, 1'b0);
      checks++;
      if (count !== 4'd7) begin failures++; $display("FAIL fill_drop: got %0d expected 7", count); end
   endtask

   task automatic test_wrap_partial_pop();
      repeat (3) drive(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
      checks++;
      if (count !== 4'd1 || valid2 !== 1'b0 || inst2_d !== 32'h0) begin
         failures++; $display("FAIL one_left: got count %0d v2 %0b inst2 %h expected 1/0/0", count, valid2, inst2_d);
      end
      drive(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
      checks++;
      if (count !== 4'd0 || valid1 !== 1'b0) begin
         failures++; $display("FAIL partial_pop: got count %0d v1 %0b expected 0/0", count, valid1);
      end
      for (int c = 0; c < 20; c++) begin
         logic [1:0] pu;
         logic [1:0] po;
         pu = 2'($urandom_range(0, 3));
         po = 2'($urandom_range(0, 3));
         drive(pu, 32'hC000_0000 + seq_n, 32'h4 * seq_n, 32'hC000_0001 + seq_n, 32'h4 * seq_n + 4, po, 1'b0);
         seq_n += 2;
      end
      while (sb.size() != 0) drive(2'd0, 0, 0, 0, 0, 2'd2, 1'b0);
      checks++;
      if (valid1 !== 1'b0) begin failures++; $display("FAIL drain_valid: got %0b expected 0", valid1); end
   endtask

   task automatic test_simultaneous();
      drive(2'd2, 32'hD0000000, 32'h200, 32'hD0000001, 32'h204, 2'd0, 1'b0);
      drive(2'd2, 32'hD0000002, 32'h208, 32'hD0000003, 32'h20C, 2'd0, 1'b0);
      drive(2'd2, 32'hD0000004, 32'h210, 32'hD0000005, 32'h214, 2'd1, 1'b0);
      checks++;
      if (count !== 4'd5) begin failures++; $display("FAIL simul_count: got %0d expected 5", count); end
      checks++;
      if (inst1_d !== 32'hD0000001) begin
         failures++; $display("FAIL simul_inst1: got %h expected D0000001", inst1_d);
      end
   endtask

   task automatic test_flush();
      drive(2'd2, 32'hEEEE0000, 32'h300, 32'hEEEE0001, 32'h304, 2'd2, 1'b1);
      checks++;
      if (count !== 4'd0 || valid1 !== 1'b0 || ready !== 1'b1) begin
         failures++; $display("FAIL flush: got count %0d v1 %0b ready %0b expected 0/0/1", count, valid1, ready);
      end
      drive(2'd1, 32'hF00DF00D, 32'h400, 0, 0, 2'd0, 1'b0);
      checks++;
      if (inst1_d !== 32'hF00DF00D || pc1_d !== 32'h400) begin
         failures++; $display("FAIL post_flush: got %h/%h expected F00DF00D/400", inst1_d, pc1_d);
      end
      drive(2'd0, 0, 0, 0, 0, 2'd1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; push_cnt = 2'd0; pop_cnt = 2'd0;
      inst1 = '0; inst2 = '0; pc1 = '0; pc2 = '0;
      @(posedge clk); #1;
      test_reset();
      test_push_pair();
      test_fill();
      test_wrap_partial_pop();
      test_simultaneous();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
